// File: rtl/frogger_pkg.sv
// -----------------------------------------------------------------------------
// frogger_pkg
// Shared definitions for the frogger PS/2 input path:
//   - PS/2 scan-code set 2 constants (prefixes, arrow keys, WASD)
//   - key index positions used by the decoder's held-key registers
//   - the PS/2 frame-receiver state enum
//   - the default frame timeout (1 ms at 50 MHz)
//   - an odd-parity helper for frame validation
// -----------------------------------------------------------------------------
package frogger_pkg;

   // Prefix bytes
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] SC_BRK   = 8'hF0;

   // Arrow keys (only meaningful after SC_EXT)
   localparam logic [7:0] SC_UP    = 8'h75;
   localparam logic [7:0] SC_DOWN  = 8'h72;
   localparam logic [7:0] SC_LEFT  = 8'h6B;
   localparam logic [7:0] SC_RIGHT = 8'h74;

   // WASD (non-extended)
   localparam logic [7:0] SC_W     = 8'h1D;
   localparam logic [7:0] SC_S     = 8'h1B;
   localparam logic [7:0] SC_A     = 8'h1C;
   localparam logic [7:0] SC_D     = 8'h23;

   // Bit positions inside the 4-bit held-key vectors
   localparam int unsigned KEY_UP    = 0;
   localparam int unsigned KEY_DOWN  = 1;
   localparam int unsigned KEY_LEFT  = 2;
   localparam int unsigned KEY_RIGHT = 3;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 50000;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StParity,
      StStop
   } ps2_state_e;

   // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// -----------------------------------------------------------------------------
// ps2_rx
// PS/2 device-to-host frame receiver. Synchronizes the raw PS/2 pins, detects
// falling edges of the PS/2 clock and assembles 11-bit frames
// (start, 8 data LSB first, odd parity, stop). A frame stalled for
// TIMEOUT_CYCLES clocks is discarded.
//
// Ports:
//   Clk         in   system clock (50 MHz)
//   Reset       in   synchronous, active-high reset
//   ps2_clk     in   raw PS/2 clock pin (asynchronous)
//   ps2_data    in   raw PS/2 data pin (asynchronous)
//   byte_out    out  last correctly received byte
//   byte_valid  out  one-cycle pulse when byte_out updates
//   frame_err   out  one-cycle pulse on parity/stop error or timeout abort
// -----------------------------------------------------------------------------
module ps2_rx
   import frogger_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter int unsigned CNT_W          = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       frame_err
);

   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT_CYCLES);

   // Two-flop synchronizers plus one history flop on the clock for edge detect
   logic clk_meta_q, clk_sync_q, clk_prev_q;
   logic data_meta_q, data_sync_q;
   logic fe;

   ps2_state_e       state_q;
   logic [2:0]       bit_cnt_q;
   logic [7:0]       shift_q;
   logic             parity_q;
   logic [CNT_W-1:0] tmo_cnt_q;

   // Idle PS/2 lines are high, so the synchronizers reset to 1 to avoid a
   // spurious falling edge right after reset.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         clk_prev_q  <= 1'b1;
         data_meta_q <= 1'b1;
         data_sync_q <= 1'b1;
      end else begin
         clk_meta_q  <= ps2_clk;
         clk_sync_q  <= clk_meta_q;
         clk_prev_q  <= clk_sync_q;
         data_meta_q <= ps2_data;
         data_sync_q <= data_meta_q;
      end
   end

   assign fe = clk_prev_q & ~clk_sync_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= StIdle;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         parity_q   <= 1'b0;
         tmo_cnt_q  <= '0;
         byte_out   <= 8'h00;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (fe || state_q == StIdle) begin
            tmo_cnt_q <= '0;
         end else begin
            tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
         end

         unique case (state_q)
            StIdle: begin
               // A high data bit on an edge is not a start bit; ignore it quietly
               if (fe && !data_sync_q) begin
                  state_q   <= StData;
                  bit_cnt_q <= 3'd0;
               end
            end
            StData: begin
               if (fe) begin
                  shift_q   <= {data_sync_q, shift_q[7:1]};
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     state_q <= StParity;
                  end
               end
            end
            StParity: begin
               if (fe) begin
                  parity_q <= data_sync_q;
                  state_q  <= StStop;
               end
            end
            StStop: begin
               if (fe) begin
                  if (data_sync_q && odd_parity_ok(shift_q, parity_q)) begin
                     byte_out   <= shift_q;
                     byte_valid <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         // Stall abort; an edge in the same cycle takes precedence
         if (!fe && state_q != StIdle && tmo_cnt_q == TMO_LIMIT) begin
            state_q   <= StIdle;
            frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ps2_arrow_decoder.sv
// -----------------------------------------------------------------------------
// ps2_arrow_decoder
// Turns PS/2 scan-code set 2 make/break sequences into held key levels for the
// frog movement block. Arrow keys (E0-extended) and WASD drive the same four
// directions; each output is the OR of its two held-key registers.
//
// Ports:
//   Clk         in   system clock (50 MHz)
//   Reset       in   synchronous, active-high reset
//   ps2_clk     in   raw PS/2 clock pin (asynchronous)
//   ps2_data    in   raw PS/2 data pin (asynchronous)
//   up          out  high while Up arrow or W is held
//   down        out  high while Down arrow or S is held
//   left        out  high while Left arrow or A is held
//   right       out  high while Right arrow or D is held
//   byte_out    out  last correctly received byte (debug display)
//   byte_valid  out  one-cycle pulse when byte_out updates
//   frame_err   out  one-cycle pulse on a receive error or timeout
// -----------------------------------------------------------------------------
module ps2_arrow_decoder
   import frogger_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT,
   parameter int unsigned CNT_W          = 16
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic       frame_err
);

   logic       ext_q;
   logic       brk_q;
   logic [3:0] arrow_q;
   logic [3:0] wasd_q;

   ps2_rx #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_rx (
      .Clk        (Clk),
      .Reset      (Reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ext_q   <= 1'b0;
         brk_q   <= 1'b0;
         arrow_q <= 4'b0000;
         wasd_q  <= 4'b0000;
      end else if (frame_err) begin
         // A lost byte may have been part of a prefix sequence; start clean
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (byte_valid) begin
         if (byte_out == SC_EXT) begin
            ext_q <= 1'b1;
         end else if (byte_out == SC_BRK) begin
            brk_q <= 1'b1;
         end else begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
            if (ext_q) begin
               case (byte_out)
                  SC_UP:    arrow_q[KEY_UP]    <= !brk_q;
                  SC_DOWN:  arrow_q[KEY_DOWN]  <= !brk_q;
                  SC_LEFT:  arrow_q[KEY_LEFT]  <= !brk_q;
                  SC_RIGHT: arrow_q[KEY_RIGHT] <= !brk_q;
                  default:  ;
               endcase
            end else begin
               case (byte_out)
                  SC_W:    wasd_q[KEY_UP]    <= !brk_q;
                  SC_S:    wasd_q[KEY_DOWN]  <= !brk_q;
                  SC_A:    wasd_q[KEY_LEFT]  <= !brk_q;
                  SC_D:    wasd_q[KEY_RIGHT] <= !brk_q;
                  default: ;
               endcase
            end
         end
      end
   end

   assign up    = arrow_q[KEY_UP]    | wasd_q[KEY_UP];
   assign down  = arrow_q[KEY_DOWN]  | wasd_q[KEY_DOWN];
   assign left  = arrow_q[KEY_LEFT]  | wasd_q[KEY_LEFT];
   assign right = arrow_q[KEY_RIGHT] | wasd_q[KEY_RIGHT];

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
module tb_ps2_arrow_decoder;

   // PS/2 half period in system clocks (kept short so the whole run stays small)
   localparam int unsigned HALF = 25;

   typedef struct packed {
      logic       err;
      logic [7:0] code;
      logic [3:0] keys;  // {right, left, down, up} expected one cycle after the event
   } sb_item_t;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       ps2_clk;
   logic       ps2_data;
   logic       up, down, left, right;
   logic [7:0] byte_out;
   logic       byte_valid;
   logic       frame_err;
   logic [3:0] keys;

   int          checks   = 0;
   int          failures = 0;
   int unsigned cyc      = 0;
   int unsigned last_fall = 0;
   sb_item_t    sb_q[$];

   ps2_arrow_decoder dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .up         (up),
      .down       (down),
      .left       (left),
      .right      (right),
      .byte_out   (byte_out),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   assign keys = {right, left, down, up};

   always #10 Clk = ~Clk;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [10:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         ps2_data = bits[i];
         repeat (HALF) @(negedge Clk);
         ps2_clk   = 1'b0;
         last_fall = cyc;
         repeat (HALF) @(negedge Clk);
         ps2_clk = 1'b1;
      end
      repeat (HALF) @(negedge Clk);
      ps2_data = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par);
      logic [10:0] bits;
      bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      send_bits(bits, 11);
   endtask

   // Good frame: expect byte b, then keys == k one cycle after byte_valid
   task automatic expect_byte(input logic [7:0] b, input logic [3:0] k);
      sb_q.push_back('{err: 1'b0, code: b, keys: k});
      send_frame(b, 1'b0);
   endtask

   // Scoreboard consumer: every byte_valid/frame_err must match the queue head
   initial begin
      sb_item_t   it;
      bit         pend;
      logic [3:0] pk;
      pend = 1'b0;
      pk   = 4'b0000;
      forever begin
         @(negedge Clk);
         if (pend) begin
            check("keys_after_event", keys, pk);
            pend = 1'b0;
         end
         if (!Reset && (byte_valid || frame_err)) begin
            if (sb_q.size() == 0) begin
               check("unexpected_event", {byte_valid, frame_err}, 2'b00);
            end else begin
               it = sb_q.pop_front();
               check("event_kind", {frame_err, byte_valid}, it.err ? 2'b10 : 2'b01);
               if (!it.err) check("byte_out", byte_out, it.code);
               pk   = it.keys;
               pend = 1'b1;
            end
         end
      end
   end

   initial begin
      int unsigned elapsed;
      logic [10:0] partial;

      Reset    = 1'b1;
      ps2_clk  = 1'b1;
      ps2_data = 1'b1;
      repeat (3) @(negedge Clk);
      check("reset_keys", keys, 4'b0000);
      check("reset_byte_out", byte_out, 8'h00);
      check("reset_byte_valid", byte_valid, 1'b0);
      check("reset_frame_err", frame_err, 1'b0);
      Reset = 1'b0;
      repeat (5) @(negedge Clk);

      // Up arrow make
      expect_byte(8'hE0, 4'b0000);
      expect_byte(8'h75, 4'b0001);
      check("up_make_up", up, 1'b1);
      check("up_make_others", {right, left, down}, 3'b000);
      check("up_make_byte", byte_out, 8'h75);

      // Up arrow break, then bare 0x75 is unmapped
      expect_byte(8'hE0, 4'b0001);
      expect_byte(8'hF0, 4'b0001);
      expect_byte(8'h75, 4'b0000);
      check("up_break", up, 1'b0);
      expect_byte(8'h75, 4'b0000);
      check("bare_75_keys", keys, 4'b0000);

      // A held, Left arrow make and break, then A break
      expect_byte(8'h1C, 4'b0100);
      expect_byte(8'hE0, 4'b0100);
      expect_byte(8'h6B, 4'b0100);
      expect_byte(8'hE0, 4'b0100);
      expect_byte(8'hF0, 4'b0100);
      expect_byte(8'h6B, 4'b0100);
      check("left_still_held_by_a", left, 1'b1);
      expect_byte(8'hF0, 4'b0100);
      expect_byte(8'h1C, 4'b0000);
      check("left_released", left, 1'b0);

      // Bad parity W, then good W, then release
      sb_q.push_back('{err: 1'b1, code: 8'h00, keys: 4'b0000});
      send_frame(8'h1D, 1'b1);
      check("bad_parity_up", up, 1'b0);
      check("bad_parity_byte_kept", byte_out, 8'h1C);
      expect_byte(8'h1D, 4'b0001);
      check("w_make_up", up, 1'b1);
      expect_byte(8'hF0, 4'b0001);
      expect_byte(8'h1D, 4'b0000);

      // Stalled frame: start + 4 data bits, then silence
      partial = 11'b000_0000_1010;
      sb_q.push_back('{err: 1'b1, code: 8'h00, keys: 4'b0000});
      send_bits(partial, 5);
      elapsed = 0;
      for (int i = 0; i < 51000; i++) begin
         @(negedge Clk);
         if (frame_err) begin
            elapsed = cyc - last_fall;
            break;
         end
      end
      check("timeout_latency_in_window",
            (elapsed >= 50000) && (elapsed <= 50010), 1'b1);
      repeat (500) @(negedge Clk);
      expect_byte(8'hE0, 4'b0000);
      expect_byte(8'h72, 4'b0010);
      check("down_after_timeout", down, 1'b1);

      // Right arrow held too, then reset in the middle of a frame after an E0
      expect_byte(8'hE0, 4'b0010);
      expect_byte(8'h74, 4'b1010);
      check("right_make", right, 1'b1);
      expect_byte(8'hE0, 4'b1010);
      partial = 11'b000_0000_0110;
      send_bits(partial, 3);
      @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      check("midframe_reset_keys", keys, 4'b0000);
      check("midframe_reset_byte_out", byte_out, 8'h00);
      check("midframe_reset_pulses", {byte_valid, frame_err}, 2'b00);
      Reset = 1'b0;
      repeat (10) @(negedge Clk);
      // Pending E0 must be gone: 0x74 alone is unmapped
      expect_byte(8'h74, 4'b0000);
      check("no_pending_ext", right, 1'b0);
      expect_byte(8'h1D, 4'b0001);
      check("decode_after_reset", up, 1'b1);

      repeat (20) @(negedge Clk);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
